if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 164 ++++++++++++++++
 tb/tb_if_id_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// Instruction fetch plus the IF/ID pipeline register. Issues word fetches to
// instruction memory, hands fetched words to the decode stage one per cycle,
// absorbs decode interlocks (stall) and downstream control-flow changes
// (redirect).
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   clr          asynchronous active-high reset
//   stall        decode cannot accept a new instruction this cycle
//   redirect     taken branch/jump resolved downstream (one-cycle pulse)
//   redirect_pc  target address, qualified by redirect
//   imem_req     fetch request (combinational from state)
//   imem_addr    registered, word-aligned fetch address
//   imem_ready   memory returns imem_rdata this cycle
//   imem_rdata   fetched instruction word
//   id_inst      instruction presented to decode
//   id_pc4       address of id_inst plus 4
//   id_valid     id_inst/id_pc4 carry a real instruction (0 = bubble)
//   pc           address of the next instruction to be delivered to decode
//   state_dbg    current FSM state (REQ=0, HOLD=1, DROP=2) for observation
//
// Memory handshake: a fetch is outstanding whenever imem_req=1; imem_addr is
// held constant until a cycle with imem_ready=1 completes it. imem_ready is
// only meaningful while imem_req=1. Decode handshake: a word moves into the
// ID registers only on a cycle with stall=0; with stall=1 the ID registers
// keep their contents (id_valid included).
// -----------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] pc,
    output logic [1:0]  state_dbg
);

    // REQ : fetch of pc outstanding
    // HOLD: fetched word parked in hold_buf while decode is stalled
    // DROP: a stale fetch is still in flight and its data must be discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] hold_buf, hold_buf_nx;
    logic [31:0] pc_nx, imem_addr_nx, id_inst_nx, id_pc4_nx;
    logic        id_valid_nx;
    logic [31:0] pc_plus4;

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state != S_HOLD);
    assign state_dbg = state;

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        imem_addr_nx = imem_addr;
        id_inst_nx   = id_inst;
        id_pc4_nx    = id_pc4;
        id_valid_nx  = id_valid;
        hold_buf_nx  = hold_buf;

        case (state)
            S_REQ: begin
                if (redirect) begin
                    // Redirect beats stall and any completing fetch.
                    id_valid_nx = 1'b0;
                    pc_nx       = redirect_pc;
                    if (imem_ready) begin
                        imem_addr_nx = redirect_pc;
                    end else begin
                        // The old fetch is still in flight; wait it out.
                        state_nx = S_DROP;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        id_inst_nx   = imem_rdata;
                        id_pc4_nx    = pc_plus4;
                        id_valid_nx  = 1'b1;
                        pc_nx        = pc_plus4;
                        imem_addr_nx = pc_plus4;
                    end else begin
                        hold_buf_nx = imem_rdata;
                        state_nx    = S_HOLD;
                    end
                end else if (!stall) begin
                    id_valid_nx = 1'b0;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    id_valid_nx  = 1'b0;
                    pc_nx        = redirect_pc;
                    imem_addr_nx = redirect_pc;
                    state_nx     = S_REQ;
                end else if (!stall) begin
                    id_inst_nx   = hold_buf;
                    id_pc4_nx    = pc_plus4;
                    id_valid_nx  = 1'b1;
                    pc_nx        = pc_plus4;
                    imem_addr_nx = pc_plus4;
                    state_nx     = S_REQ;
                end
            end

            S_DROP: begin
                id_valid_nx = 1'b0;
                if (redirect) begin
                    // Latest redirect wins; pc already tracks it.
                    pc_nx = redirect_pc;
                    if (imem_ready) begin
                        imem_addr_nx = redirect_pc;
                        state_nx     = S_REQ;
                    end
                end else if (imem_ready) begin
                    imem_addr_nx = pc;
                    state_nx     = S_REQ;
                end
            end

            default: begin
                state_nx = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            id_inst   <= 32'h0;
            id_pc4    <= 32'h0;
            id_valid  <= 1'b0;
            hold_buf  <= 32'h0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            imem_addr <= imem_addr_nx;
            id_inst   <= id_inst_nx;
            id_pc4    <= id_pc4_nx;
            id_valid  <= id_valid_nx;
            hold_buf  <= hold_buf_nx;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [1:0]  ST_REQ  = 2'd0;
  localparam logic [1:0]  ST_HOLD = 2'd1;
  localparam logic [1:0]  ST_DROP = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [31:0] pc;
  logic [1:0]  state_dbg;

  // Memory model: word at address a is (a ^ mem_key); answers only when asked.
  logic        rdy_drv = 1'b0;
  logic [31:0] mem_key = 32'h0;
  assign imem_ready = rdy_drv & imem_req;
  assign imem_rdata = imem_ready ? (imem_addr ^ mem_key) : 32'hDEAD_BEEF;

  if_id_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .clr(clr), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .id_inst(id_inst),
    .id_pc4(id_pc4), .id_valid(id_valid), .pc(pc), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  logic [31:0] exp_pc;      // address of the next instruction decode must see
  logic [31:0] exp_q[$];    // explicitly expected delivered words, in order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + reference model ----------------
  // Applies one cycle of inputs, then checks the outcome against the program-
  // order model: deliveries must be exactly exp_pc, exp_pc+4, ... and a
  // redirect restarts the stream at its target.
  task automatic step(input logic s, input logic rdy, input logic rd, input logic [31:0] rp);
    logic        p_req, p_valid, p_ready, must;
    logic [31:0] p_addr, p_inst, p_pc4, head;
    stall = s; rdy_drv = rdy; redirect = rd; redirect_pc = rp;
    #1;
    p_req = imem_req; p_addr = imem_addr; p_ready = imem_ready;
    p_inst = id_inst; p_pc4 = id_pc4; p_valid = id_valid;
    // A delivery is owed when the wanted word is returned (or already parked)
    // and decode is free and no redirect intervenes.
    must = !rd && !s && (p_req ? (p_ready && (p_addr == exp_pc)) : 1'b1);
    @(posedge clk);
    #1;
    if (rd) begin
      chk("redirect_bubble", {31'h0, id_valid}, 32'h0);
      exp_pc = rp;
    end else if (s) begin
      chk("stall_inst", id_inst, p_inst);
      chk("stall_pc4", id_pc4, p_pc4);
      chk("stall_valid", {31'h0, id_valid}, {31'h0, p_valid});
    end else begin
      if (must) chk("deliver", {31'h0, id_valid}, 32'h1);
      if (id_valid) begin
        chk("inst", id_inst, exp_pc ^ mem_key);
        chk("pc4", id_pc4, exp_pc + 32'd4);
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          chk("seq", id_inst, head);
        end
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end
    chk("pc", pc, exp_pc);
    if (p_req && !p_ready) chk("addr_stable", imem_addr, p_addr);
    if (!p_req && s && !rd) chk("hold_no_req", {31'h0, imem_req}, 32'h0);
    chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, {30'h0, state_dbg}, {30'h0, ST_REQ});
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_addr"}, imem_addr, RST_PC);
    chk({tag, "_inst"}, id_inst, 32'h0);
    chk({tag, "_pc4"}, id_pc4, 32'h0);
    chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          d0;
    logic [31:0] rp;
    logic        s, r, rd;

    // Reset and first request
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    clr = 1'b0;
    exp_pc = RST_PC;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RST_PC);

    // Zero-wait stream across the 32-bit wrap
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("zw_valid", {31'h0, id_valid}, 32'h1);
    end
    chk("zw_all_seen", exp_q.size(), 32'h0);

    // Two wait states per fetch: id_valid 0,0,1
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    for (int f = 0; f < 2; f++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("ws_v0a", {31'h0, id_valid}, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("ws_v0b", {31'h0, id_valid}, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("ws_v1", {31'h0, id_valid}, 32'h1);
    end

    // Stall for three cycles while the word at 0x18 returns
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("st_state", {30'h0, state_dbg}, {30'h0, ST_HOLD});
    chk("st_req", {31'h0, imem_req}, 32'h0);
    chk("st_inst", id_inst, 32'h14);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("st_inst_held", id_inst, 32'h14);
    exp_q.push_back(32'h18);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("st_release_inst", id_inst, 32'h18);
    chk("st_next_addr", imem_addr, 32'h1C);
    chk("st_next_req", {31'h0, imem_req}, 32'h1);

    // Redirect to 0x100 while fetch of 0x1C is pending
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h100);
    chk("rd_state_drop", {30'h0, state_dbg}, {30'h0, ST_DROP});
    chk("rd_addr_kept", imem_addr, 32'h1C);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_stale_dropped", {31'h0, id_valid}, 32'h0);
    chk("rd_refetch_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rd_target_inst", id_inst, 32'h100);

    // Redirect, stall and ready together
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("rsr_pc", pc, 32'h200);
    chk("rsr_state", {30'h0, state_dbg}, {30'h0, ST_REQ});
    chk("rsr_addr", imem_addr, 32'h200);
    exp_q.push_back(32'h200);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rsr_q_empty", exp_q.size(), 32'h0);

    // Randomized traffic against the program-order model
    mem_key = 32'hA5A5_0000;
    d0 = n_deliv;
    for (int i = 0; i < 800; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 9) == 0);
      rp = 32'h0001_0000 + ($urandom_range(0, 255) << 2);
      // A target equal to a stale in-flight address would make the model
      // unable to tell the stale return from the wanted one.
      if (rp == imem_addr) rp = rp + 32'd4;
      step(s, r, rd, rd ? rp : 32'h0);
    end
    chk("rand_liveness", {31'h0, (n_deliv - d0) > 100}, 32'h1);

    // Reset asserted mid-wait: outputs clear at once, not at the next edge
    step(1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    clr = 1'b1;
    rdy_drv = 1'b0;
    mem_key = 32'h0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_pc = RST_PC;
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, RST_PC);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rel_first_inst", id_inst, RST_PC);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rel_wrap_inst", id_inst, 32'h0);
    chk("rel_q_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
